// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_flagged #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_write,
  input  logic                  fifo_read,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [CW-1:0]         fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);
  localparam int AW = CW - 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      !(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL < DEPTH)) begin : g_bad_params
    $error("fifo_flagged: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  assign fifo_full         = (cnt_q == CW'(DEPTH));
  assign fifo_empty        = (cnt_q == '0);
  assign fifo_almost_full  = (cnt_q >= CW'(AF_LEVEL));
  assign fifo_almost_empty = (cnt_q <= CW'(AE_LEVEL));
  assign fifo_count        = cnt_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

  // Full rejects the write and empty rejects the read, so a simultaneous
  // request at either extreme degrades to the single legal operation.
  assign wr_acc = fifo_write && !fifo_full;
  assign rd_acc = fifo_read  && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // set beats clear when both land on the same edge
    ovf_d = (fifo_write && fifo_full)  ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    unf_d = (fifo_read  && fifo_empty) ? 1'b1 : (err_clr ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= fifo_data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign fifo_data_out = fifo_empty ? '0 : mem[rd_ptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
    assign fifo_data_out = dout_q;
  end
endmodule
